// File: rtl/register_file.sv
// 32-entry register file: two combinational read ports with write-through bypass,
// one gated write port, hard-wired zero register, asynchronous active-high reset.
module register_file #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WriteEnable,
  input  logic [ADDR-1:0]  WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [ADDR-1:0]  ReadReg1,
  input  logic [ADDR-1:0]  ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam int NREG = 2 ** ADDR;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  wr_dec_s;
  logic             byp1_s;
  logic             byp2_s;
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;

  // One-hot write decoder, gated by the write strobe.
  always_comb begin
    wr_dec_s = {NREG{1'b0}};
    if (WriteEnable) begin
      wr_dec_s[WriteReg] = 1'b1;
    end else begin
      wr_dec_s = {NREG{1'b0}};
    end
  end

  // Next-state: selected register loads, register 0 is pinned to zero.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (i == 0) begin
        regs_d[i] = {WIDTH{1'b0}};
      end else if (wr_dec_s[i]) begin
        regs_d[i] = WriteData;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass stays live during reset so an in-flight write is visible before the edge.
  assign byp1_s = WriteEnable && (WriteReg != {ADDR{1'b0}}) && (WriteReg == ReadReg1);
  assign byp2_s = WriteEnable && (WriteReg != {ADDR{1'b0}}) && (WriteReg == ReadReg2);

  // Read port 1 selection.
  always_comb begin
    if (byp1_s) begin
      rd1_s = WriteData;
    end else begin
      rd1_s = regs_q[ReadReg1];
    end
  end

  // Read port 2 selection.
  always_comb begin
    if (byp2_s) begin
      rd2_s = WriteData;
    end else begin
      rd2_s = regs_q[ReadReg2];
    end
  end

  assign ReadData1 = rd1_s;
  assign ReadData2 = rd2_s;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: behavioural array model compared every
// falling edge, plus directed literal checks and randomized traffic.
`timescale 1ns/1ps
module tb_register_file;

  logic        Clk;
  logic        Reset;
  logic        WriteEnable;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int          n_cmp;
  int          n_bad;
  bit          chk_en;
  logic [31:0] model [32];

  register_file #(.WIDTH(32), .ADDR(5)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .WriteEnable(WriteEnable),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] exp_rd(input logic [4:0] sel);
    if (WriteEnable && WriteReg != 5'd0 && WriteReg == sel) return WriteData;
    return model[sel];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    WriteEnable = 1'b1;
    WriteReg    = r;
    WriteData   = d;
    step();
    WriteEnable = 1'b0;
  endtask

  task automatic fill();
    for (int n = 1; n < 32; n++) wr(5'(n), 32'(n));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    chk_en = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    Reset = 1'b1;
    WriteEnable = 1'b0;
    WriteReg = 5'd0;
    WriteData = 32'd0;
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    fork
      // Model update: spec rules, asynchronous clear.
      forever begin
        @(posedge Clk or posedge Reset);
        if (Reset) begin
          for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (WriteEnable && WriteReg != 5'd0) begin
          model[WriteReg] = WriteData;
        end
      end
      // Compare process.
      forever begin
        @(negedge Clk);
        if (chk_en) begin
          chk("model_rd1", ReadData1, exp_rd(ReadReg1));
          chk("model_rd2", ReadData2, exp_rd(ReadReg2));
        end
      end
      // Stimulus.
      begin
        step();
        step();
        Reset = 1'b0;
        chk_en = 1'b1;
        ReadReg1 = 5'd7;
        ReadReg2 = 5'd31;
        #1;
        chk("reset_state_rd1", ReadData1, 32'd0);
        chk("reset_state_rd2", ReadData2, 32'd0);

        // Write/read sweep.
        fill();
        begin
          logic [4:0] sweep [7];
          sweep = '{5'd1, 5'd4, 5'd5, 5'd7, 5'd21, 5'd14, 5'd3};
          foreach (sweep[k]) begin
            ReadReg1 = sweep[k];
            ReadReg2 = sweep[k];
            #1;
            chk("sweep_rd1", ReadData1, 32'(sweep[k]));
            chk("sweep_rd2", ReadData2, 32'(sweep[k]));
          end
        end

        // Mid-cycle reset pulse: everything reads zero before any edge.
        step();
        #1;
        Reset = 1'b1;
        for (int s = 0; s < 32; s++) begin
          ReadReg1 = 5'(s);
          ReadReg2 = 5'(31 - s);
          #0.05;
          chk("async_reset_rd1", ReadData1, 32'd0);
          chk("async_reset_rd2", ReadData2, 32'd0);
        end
        step();
        Reset = 1'b0;

        // Register 0 ignores writes.
        fill();
        ReadReg1 = 5'd0;
        WriteEnable = 1'b1;
        WriteReg = 5'd0;
        WriteData = 32'hDEADBEEF;
        #1;
        chk("reg0_before", ReadData1, 32'd0);
        step();
        WriteEnable = 1'b0;
        #1;
        chk("reg0_after", ReadData1, 32'd0);

        // Bypass on both ports.
        ReadReg1 = 5'd9;
        ReadReg2 = 5'd9;
        #1;
        chk("bypass_pre", ReadData1, 32'd9);
        WriteEnable = 1'b1;
        WriteReg = 5'd9;
        WriteData = 32'd99;
        #1;
        chk("bypass_rd1", ReadData1, 32'd99);
        chk("bypass_rd2", ReadData2, 32'd99);
        step();
        WriteEnable = 1'b0;
        #1;
        chk("bypass_post_rd1", ReadData1, 32'd99);
        chk("bypass_post_rd2", ReadData2, 32'd99);

        // Write gate closed across three edges.
        WriteReg = 5'd12;
        WriteData = 32'd77;
        ReadReg2 = 5'd12;
        step();
        step();
        step();
        chk("write_gate", ReadData2, 32'd12);

        // Reset colliding with a write; bypass stays visible during reset.
        Reset = 1'b1;
        WriteEnable = 1'b1;
        WriteReg = 5'd5;
        WriteData = 32'd55;
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd5;
        #1;
        chk("reset_bypass", ReadData2, 32'd55);
        step();
        Reset = 1'b0;
        WriteEnable = 1'b0;
        #1;
        chk("collision_discard", ReadData1, 32'd0);
        wr(5'd5, 32'd55);
        #1;
        chk("collision_rewrite", ReadData1, 32'd55);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
          Reset       = ($urandom_range(0, 39) == 0);
          WriteEnable = $urandom_range(0, 1);
          WriteReg    = 5'($urandom_range(0, 31));
          WriteData   = $urandom;
          ReadReg1    = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
          ReadReg2    = ($urandom_range(0, 3) == 0) ? ReadReg1 : 5'($urandom_range(0, 31));
          step();
        end
        Reset = 1'b0;
        WriteEnable = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    join
  end

endmodule
